rx_ctrl_uart0: RTL and testbench



---
 rtl/uart_frame_pkg.sv | 40 ++++
 rtl/rx_head_hunt.sv | 35 +++
 rtl/rx_ctrl_uart0.sv | 223 ++++++++++++++++++++++
 tb/tb_rx_ctrl_uart0.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_frame_pkg.sv
// Shared UART0 frame definitions: header, version/count defaults, record types,
// error codes and the parser state encoding used by both directions.
package uart_frame_pkg;

  localparam logic [31:0] HEAD_DEF       = 32'h7FFF7FFF;
  localparam logic [15:0] VERSION_DEF    = 16'd0;
  localparam int          NUM_SIGNAL_DEF = 16;
  localparam logic [19:0] TIMEOUT_DEF    = 20'd100000;

  localparam logic [7:0] TYPE_DIG = 8'h03;
  localparam logic [7:0] TYPE_ANA = 8'h0C;

  localparam logic [2:0] ERR_NONE = 3'd0;
  localparam logic [2:0] ERR_VER  = 3'd1;
  localparam logic [2:0] ERR_CNT  = 3'd2;
  localparam logic [2:0] ERR_IDX  = 3'd3;
  localparam logic [2:0] ERR_TYPE = 3'd4;
  localparam logic [2:0] ERR_TMO  = 3'd5;

  typedef enum logic [1:0] {
    ST_HUNT = 2'd0,
    ST_VER  = 2'd1,
    ST_REC  = 2'd2
  } frame_state_e;

  // Byte sel of word1 in wire order: ver lo, ver hi, count lo, count hi.
  function automatic logic [7:0] word1_byte(input logic [15:0] ver,
                                            input logic [15:0] num,
                                            input logic [1:0]  sel);
    logic [7:0] b;
    case (sel)
      2'd0:    b = ver[7:0];
      2'd1:    b = ver[15:8];
      2'd2:    b = num[7:0];
      default: b = num[15:8];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/rx_head_hunt.sv
// Header hunter: 32-bit byte shift register (newest byte in the top lane, as the
// header is sent LSB byte first) plus the HEAD comparator.
module rx_head_hunt
  import uart_frame_pkg::*;
#(
  parameter logic [31:0] HEAD = HEAD_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       shift_en,
  input  logic       clr,
  input  logic [7:0] byte_in,
  output logic       match
);

  logic [31:0] sr_q, sr_d, sr_next;

  always_comb begin
    sr_next = {byte_in, sr_q[31:8]};
    match   = shift_en && (sr_next == HEAD);
    sr_d    = sr_q;
    // Clearing on a match keeps header bytes from seeding the next hunt.
    if (clr || match) begin
      sr_d = '0;
    end else if (shift_en) begin
      sr_d = sr_next;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sr_q <= '0;
    else      sr_q <= sr_d;
  end

endmodule

// File: rtl/rx_ctrl_uart0.sv
// UART0 receive frame parser: drains the RX FIFO, finds the header, checks the
// version/count word and emits one strobe per 4-byte signal record.
module rx_ctrl_uart0
  import uart_frame_pkg::*;
#(
  parameter logic [15:0] VERSION    = VERSION_DEF,
  parameter int          NUM_SIGNAL = NUM_SIGNAL_DEF,
  parameter logic [31:0] HEAD       = HEAD_DEF,
  parameter logic [19:0] TIMEOUT    = TIMEOUT_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ena,
  input  logic        rx_fifo_empty,
  output logic        rx_fifo_ren,
  input  logic [7:0]  rx_fifo_rdata,
  output logic        sig_val,
  output logic [4:0]  sig_idx,
  output logic        sig_analog,
  output logic [15:0] sig_data,
  output logic        frame_ok,
  output logic        frame_err,
  output logic [2:0]  err_code,
  output logic [15:0] frame_cnt,
  output logic [15:0] err_cnt
);

  localparam logic [15:0] NUM_W    = 16'(NUM_SIGNAL);
  localparam logic [4:0]  LAST_REC = 5'(NUM_SIGNAL - 1);

  frame_state_e state_q, state_d;

  logic        byte_v_q, byte_v_d, bv;
  logic [1:0]  bcnt_q, bcnt_d;
  logic [4:0]  rcnt_q, rcnt_d;
  logic [19:0] tmo_q, tmo_d;
  logic [4:0]  idx_q, idx_d;
  logic        ana_q, ana_d;
  logic [7:0]  lo_q, lo_d;

  logic        sig_val_q, sig_val_d;
  logic [4:0]  sig_idx_q, sig_idx_d;
  logic        sig_analog_q, sig_analog_d;
  logic [15:0] sig_data_q, sig_data_d;
  logic        frame_ok_q, frame_ok_d;
  logic        frame_err_q, frame_err_d;
  logic [2:0]  err_code_q, err_code_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic [15:0] err_cnt_q, err_cnt_d;

  logic       match, hunt_shift, hunt_clr;
  logic       byte_bad, tmo_hit, err_fire, last_rec;
  logic [2:0] err_now;

  // Handshake: ren is only raised with no byte in flight; the FIFO presents
  // rdata on the following cycle, marked by byte_v. Dropping ena discards it.
  assign rx_fifo_ren = ena && !rx_fifo_empty && !byte_v_q;
  assign byte_v_d    = rx_fifo_ren;
  assign bv          = byte_v_q && ena;

  assign hunt_shift = bv && (state_q == ST_HUNT);
  assign hunt_clr   = !ena || err_fire;

  rx_head_hunt #(.HEAD(HEAD)) u_hunt (
    .clk      (clk),
    .rst      (rst),
    .shift_en (hunt_shift),
    .clr      (hunt_clr),
    .byte_in  (rx_fifo_rdata),
    .match    (match)
  );

  // Byte checks and timeout; a byte this cycle always pre-empts the timeout.
  always_comb begin
    byte_bad = 1'b0;
    err_now  = ERR_NONE;
    if (bv) begin
      case (state_q)
        ST_VER: begin
          if (rx_fifo_rdata != word1_byte(VERSION, NUM_W, bcnt_q)) begin
            byte_bad = 1'b1;
            err_now  = bcnt_q[1] ? ERR_CNT : ERR_VER;
          end
        end
        ST_REC: begin
          if ((bcnt_q == 2'd0) && (rx_fifo_rdata != {3'b000, rcnt_q})) begin
            byte_bad = 1'b1;
            err_now  = ERR_IDX;
          end else if ((bcnt_q == 2'd1) && (rx_fifo_rdata != TYPE_DIG) &&
                       (rx_fifo_rdata != TYPE_ANA)) begin
            byte_bad = 1'b1;
            err_now  = ERR_TYPE;
          end
        end
        default: ;
      endcase
    end
    tmo_hit = ena && !bv && (state_q != ST_HUNT) && (tmo_q == TIMEOUT - 20'd1);
    if (tmo_hit) err_now = ERR_TMO;
    err_fire = byte_bad || tmo_hit;
    last_rec = bv && (state_q == ST_REC) && (bcnt_q == 2'd3) && (rcnt_q == LAST_REC);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_HUNT;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (!ena || err_fire) begin
      state_d = ST_HUNT;
    end else begin
      case (state_q)
        ST_HUNT: if (match) state_d = ST_VER;
        ST_VER:  if (bv && (bcnt_q == 2'd3)) state_d = ST_REC;
        ST_REC:  if (last_rec) state_d = ST_HUNT;
        default: state_d = ST_HUNT;
      endcase
    end
  end

  always_comb begin
    bcnt_d       = bcnt_q;
    rcnt_d       = rcnt_q;
    idx_d        = idx_q;
    ana_d        = ana_q;
    lo_d         = lo_q;
    tmo_d        = '0;
    sig_val_d    = 1'b0;
    sig_idx_d    = sig_idx_q;
    sig_analog_d = sig_analog_q;
    sig_data_d   = sig_data_q;
    frame_ok_d   = 1'b0;
    frame_err_d  = 1'b0;
    err_code_d   = err_code_q;
    frame_cnt_d  = frame_cnt_q;
    err_cnt_d    = err_cnt_q;

    if ((state_q != ST_HUNT) && !bv) tmo_d = tmo_q + 20'd1;

    if (!ena || err_fire || (state_q == ST_HUNT)) begin
      bcnt_d = '0;
      rcnt_d = '0;
    end else if (bv) begin
      // The 2-bit counter wraps 3->0 at the VER->REC hand-over and per record.
      bcnt_d = bcnt_q + 2'd1;
      if (state_q == ST_REC) begin
        case (bcnt_q)
          2'd0: idx_d = rx_fifo_rdata[4:0];
          2'd1: ana_d = (rx_fifo_rdata == TYPE_ANA);
          2'd2: lo_d  = rx_fifo_rdata;
          default: begin
            sig_val_d    = 1'b1;
            sig_idx_d    = idx_q;
            sig_analog_d = ana_q;
            sig_data_d   = {rx_fifo_rdata, lo_q};
            rcnt_d       = rcnt_q + 5'd1;
            if (last_rec) begin
              frame_ok_d  = 1'b1;
              frame_cnt_d = frame_cnt_q + 16'd1;
            end
          end
        endcase
      end
    end

    if (err_fire) begin
      frame_err_d = 1'b1;
      err_code_d  = err_now;
      if (err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      byte_v_q     <= 1'b0;
      bcnt_q       <= '0;
      rcnt_q       <= '0;
      tmo_q        <= '0;
      idx_q        <= '0;
      ana_q        <= 1'b0;
      lo_q         <= '0;
      sig_val_q    <= 1'b0;
      sig_idx_q    <= '0;
      sig_analog_q <= 1'b0;
      sig_data_q   <= '0;
      frame_ok_q   <= 1'b0;
      frame_err_q  <= 1'b0;
      err_code_q   <= ERR_NONE;
      frame_cnt_q  <= '0;
      err_cnt_q    <= '0;
    end else begin
      byte_v_q     <= byte_v_d;
      bcnt_q       <= bcnt_d;
      rcnt_q       <= rcnt_d;
      tmo_q        <= tmo_d;
      idx_q        <= idx_d;
      ana_q        <= ana_d;
      lo_q         <= lo_d;
      sig_val_q    <= sig_val_d;
      sig_idx_q    <= sig_idx_d;
      sig_analog_q <= sig_analog_d;
      sig_data_q   <= sig_data_d;
      frame_ok_q   <= frame_ok_d;
      frame_err_q  <= frame_err_d;
      err_code_q   <= err_code_d;
      frame_cnt_q  <= frame_cnt_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  assign sig_val    = sig_val_q;
  assign sig_idx    = sig_idx_q;
  assign sig_analog = sig_analog_q;
  assign sig_data   = sig_data_q;
  assign frame_ok   = frame_ok_q;
  assign frame_err  = frame_err_q;
  assign err_code   = err_code_q;
  assign frame_cnt  = frame_cnt_q;
  assign err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_rx_ctrl_uart0.sv
// Directed bench for rx_ctrl_uart0: byte-FIFO model, record scoreboard,
// hand-computed counters and error codes per scenario.
module tb_rx_ctrl_uart0;

  localparam int TMO = 100;

  logic        clk = 1'b0;
  logic        rst;
  logic        ena;
  logic        rx_fifo_empty;
  logic        rx_fifo_ren;
  logic [7:0]  rx_fifo_rdata;
  logic        sig_val;
  logic [4:0]  sig_idx;
  logic        sig_analog;
  logic [15:0] sig_data;
  logic        frame_ok;
  logic        frame_err;
  logic [2:0]  err_code;
  logic [15:0] frame_cnt;
  logic [15:0] err_cnt;

  rx_ctrl_uart0 #(.TIMEOUT(20'd100)) dut (
    .clk           (clk),
    .rst           (rst),
    .ena           (ena),
    .rx_fifo_empty (rx_fifo_empty),
    .rx_fifo_ren   (rx_fifo_ren),
    .rx_fifo_rdata (rx_fifo_rdata),
    .sig_val       (sig_val),
    .sig_idx       (sig_idx),
    .sig_analog    (sig_analog),
    .sig_data      (sig_data),
    .frame_ok      (frame_ok),
    .frame_err     (frame_err),
    .err_code      (err_code),
    .frame_cnt     (frame_cnt),
    .err_cnt       (err_cnt)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- RX FIFO model (normal mode) ----------------
  logic [7:0] mem [0:4095];
  int wr_ptr = 0;
  int rd_ptr = 0;
  assign rx_fifo_empty = (wr_ptr == rd_ptr);
  always @(posedge clk) begin
    if (rx_fifo_ren) begin
      rx_fifo_rdata <= mem[rd_ptr];
      rd_ptr        <= rd_ptr + 1;
    end
  end

  // ---------------- scoreboard ----------------
  logic [21:0] exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;
  int ok_seen = 0;
  int err_seen = 0;
  int err_cyc = 0;
  int last_ren_cyc = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [21:0] e;
    if (rx_fifo_ren) last_ren_cyc = cyc;
    if (sig_val) begin
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 22'h3FFFFF;
      check("rec", {10'd0, sig_idx, sig_analog, sig_data}, {10'd0, e});
    end
    if (frame_ok) begin
      ok_seen++;
      check("ok_with_val", {31'd0, sig_val}, 32'd1);
    end
    if (frame_err) begin
      err_seen++;
      err_cyc = cyc;
    end
  end

  // ---------------- driver tasks ----------------
  function automatic logic [15:0] rec_data(input int i);
    if (i == 2) return 16'h1234;
    return 16'hC000 | (16'(i) * 16'h0101);
  endfunction

  function automatic logic [7:0] rec_type(input int i);
    return (i % 2 == 0) ? 8'h0C : 8'h03;
  endfunction

  task automatic push_byte(input logic [7:0] b);
    mem[wr_ptr] = b;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic push_head_ver(input logic [7:0] cnt_lo);
    push_byte(8'hFF); push_byte(8'h7F); push_byte(8'hFF); push_byte(8'h7F);
    push_byte(8'h00); push_byte(8'h00); push_byte(cnt_lo); push_byte(8'h00);
  endtask

  task automatic push_good_recs(input int n);
    logic [15:0] d;
    for (int i = 0; i < n; i++) begin
      d = rec_data(i);
      push_byte(8'(i)); push_byte(rec_type(i)); push_byte(d[7:0]); push_byte(d[15:8]);
      exp_q.push_back({5'(i), rec_type(i) == 8'h0C, d});
    end
  endtask

  task automatic wait_idle();
    bit done = 0;
    for (int i = 0; i < 2000 && !done; i++) begin
      @(negedge clk);
      if (wr_ptr == rd_ptr && !rx_fifo_ren) done = 1;
    end
    check("drain_bound", {31'd0, done}, 32'd1);
    repeat (4) @(negedge clk);
  endtask

  task automatic good_frame(input int exp_frames, input int exp_errs);
    push_head_ver(8'h10);
    push_good_recs(16);
    wait_idle();
    check("frame_cnt", {16'd0, frame_cnt}, 32'(exp_frames));
    check("err_cnt", {16'd0, err_cnt}, 32'(exp_errs));
    check("exp_q_empty", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic reset_check(input string tag);
    check({tag, "_sig_val"}, {31'd0, sig_val}, 32'd0);
    check({tag, "_sig_idx"}, {27'd0, sig_idx}, 32'd0);
    check({tag, "_sig_analog"}, {31'd0, sig_analog}, 32'd0);
    check({tag, "_sig_data"}, {16'd0, sig_data}, 32'd0);
    check({tag, "_frame_ok"}, {31'd0, frame_ok}, 32'd0);
    check({tag, "_frame_err"}, {31'd0, frame_err}, 32'd0);
    check({tag, "_err_code"}, {29'd0, err_code}, 32'd0);
    check({tag, "_frame_cnt"}, {16'd0, frame_cnt}, 32'd0);
    check({tag, "_err_cnt"}, {16'd0, err_cnt}, 32'd0);
    check({tag, "_ren"}, {31'd0, rx_fifo_ren}, 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    bit got_err;
    rst = 1'b0;
    ena = 1'b1;
    repeat (3) @(negedge clk);
    reset_check("rst0");
    rst = 1'b1;
    @(negedge clk);

    // Good frame; last record 15 is digital with data CF0F and stays held.
    good_frame(1, 0);
    check("ok_seen1", 32'(ok_seen), 32'd1);
    check("hold_idx", {27'd0, sig_idx}, 32'd15);
    check("hold_analog", {31'd0, sig_analog}, 32'd0);
    check("hold_data", {16'd0, sig_data}, 32'h0000CF0F);

    // Garbage whose tail forms the second header candidate.
    push_byte(8'h55); push_byte(8'hFF); push_byte(8'h7F); push_byte(8'hFF);
    good_frame(2, 0);
    check("ok_seen2", 32'(ok_seen), 32'd2);

    // Count word 0F 00 -> count error, no records.
    push_head_ver(8'h0F);
    wait_idle();
    check("cnt_err_seen", 32'(err_seen), 32'd1);
    check("cnt_err_code", {29'd0, err_code}, 32'd2);
    check("cnt_err_cnt", {16'd0, err_cnt}, 32'd1);
    good_frame(3, 1);

    // Record 5 index byte 06 -> 5 records then index error.
    push_head_ver(8'h10);
    push_good_recs(5);
    push_byte(8'h06);
    wait_idle();
    check("idx_err_code", {29'd0, err_code}, 32'd3);
    check("idx_err_cnt", {16'd0, err_cnt}, 32'd2);
    check("idx_exp_q", 32'(exp_q.size()), 32'd0);

    // Record 5 type 07 -> type error.
    push_head_ver(8'h10);
    push_good_recs(5);
    push_byte(8'h05); push_byte(8'h07);
    wait_idle();
    check("type_err_code", {29'd0, err_code}, 32'd4);
    check("type_err_cnt", {16'd0, err_cnt}, 32'd3);
    check("frame_cnt_hold", {16'd0, frame_cnt}, 32'd3);

    // Bytes stop after record 3: ren at n, byte at n+1, TIMEOUT idle cycles
    // to the hit, frame_err one cycle later -> n + TIMEOUT + 2.
    push_head_ver(8'h10);
    push_good_recs(4);
    got_err = 0;
    for (int i = 0; i < 600 && !got_err; i++) begin
      @(negedge clk);
      if (err_seen == 4) got_err = 1;
    end
    check("tmo_seen", {31'd0, got_err}, 32'd1);
    check("tmo_latency", 32'(err_cyc - last_ren_cyc), 32'(TMO + 2));
    check("tmo_err_code", {29'd0, err_code}, 32'd5);
    check("tmo_err_cnt", {16'd0, err_cnt}, 32'd4);
    check("tmo_state_hunt", {30'd0, dut.state_q}, 32'd0);
    repeat (2) @(negedge clk);
    good_frame(4, 4);

    // ena dropped while record 0 is streaming: no record, no error.
    push_head_ver(8'h10);
    push_byte(8'h00); push_byte(8'h0C); push_byte(8'h34);
    repeat (19) @(negedge clk);
    ena = 1'b0;
    repeat (5) @(negedge clk);
    ena = 1'b1;
    repeat (150) @(negedge clk);
    check("ena_err_cnt", {16'd0, err_cnt}, 32'd4);
    check("ena_err_seen", 32'(err_seen), 32'd4);
    good_frame(5, 4);

    // Reset mid-record: back to reset values, then a clean frame.
    push_head_ver(8'h10);
    push_byte(8'h00); push_byte(8'h0C);
    wait_idle();
    rst = 1'b0;
    @(negedge clk);
    reset_check("rst1");
    rst = 1'b1;
    @(negedge clk);
    good_frame(1, 0);
    check("ok_seen_total", 32'(ok_seen), 32'd6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
